// File: rtl/pi1r.sv
// Round-robin arbiter letting MASTERCOUNT PI masters share one PI slave.
// Completions are single-cycle pulses; optional watchdog forces a completion when the slave stalls.
module pi1r #(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32,
  parameter int TIMEOUT     = 0,
  localparam int SELW       = ARCHBITSZ / 8,
  localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ / 8),
  localparam int GW         = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1,
  localparam int CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [2*MASTERCOUNT-1:0]         m_op_i_flat,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i_flat,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i_flat,
  input  logic [SELW*MASTERCOUNT-1:0]      m_sel_i_flat,
  output logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_o_flat,
  output logic [MASTERCOUNT-1:0]           m_rdy_o_flat,
  output logic [1:0]                       s_op_o,
  output logic [ADDRBITSZ-1:0]             s_addr_o,
  output logic [ARCHBITSZ-1:0]             s_data_o,
  output logic [SELW-1:0]                  s_sel_o,
  input  logic [ARCHBITSZ-1:0]             s_data_i,
  input  logic                             s_rdy_i,
  output logic [GW-1:0]                    gnt_o,
  output logic                             to_o
);

  // state | meaning
  // IDLE  | bus free, scanning requests starting after the last grant
  // BUSY  | granted master's op presented to the slave, awaiting s_rdy_i or watchdog
  // DONE  | completion pulse visible to the granted master, slave sees NOOP
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                 state, state_nx;
  logic [GW-1:0]          gnt, winner, cand;
  logic                   req_any, to_hit, to_q;
  logic [MASTERCOUNT-1:0] req, rdy_q;
  logic [CW-1:0]          cnt;

  logic [1:0]           m_op   [MASTERCOUNT];
  logic [ADDRBITSZ-1:0] m_addr [MASTERCOUNT];
  logic [ARCHBITSZ-1:0] m_data [MASTERCOUNT];
  logic [SELW-1:0]      m_sel  [MASTERCOUNT];
  logic [ARCHBITSZ-1:0] rdata_q[MASTERCOUNT];

  for (genvar i = 0; i < MASTERCOUNT; i++) begin : g_unpack
    assign m_op[i]   = m_op_i_flat[i*2 +: 2];
    assign m_addr[i] = m_addr_i_flat[i*ADDRBITSZ +: ADDRBITSZ];
    assign m_data[i] = m_data_i_flat[i*ARCHBITSZ +: ARCHBITSZ];
    assign m_sel[i]  = m_sel_i_flat[i*SELW +: SELW];
    assign req[i]    = |m_op[i];
    assign m_data_o_flat[i*ARCHBITSZ +: ARCHBITSZ] = rdata_q[i];
  end

  assign to_hit       = (TIMEOUT > 0) && (cnt == TO_LAST);
  assign m_rdy_o_flat = rdy_q;
  assign to_o         = to_q;
  assign gnt_o        = gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req_any  = 1'b0;
    winner   = gnt;
    cand     = '0;
    s_op_o   = 2'b00;
    s_addr_o = m_addr[gnt];
    s_data_o = m_data[gnt];
    s_sel_o  = m_sel[gnt];
    // Walk from farthest to nearest so the closest requester after gnt wins.
    for (int k = MASTERCOUNT; k >= 1; k--) begin
      cand = GW'((int'(gnt) + k) % MASTERCOUNT);
      if (req[cand]) begin
        req_any = 1'b1;
        winner  = cand;
      end
    end
    case (state)
      IDLE: if (req_any) state_nx = BUSY;
      BUSY: begin
        s_op_o = m_op[gnt];
        if (s_rdy_i || to_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      gnt   <= GW'(MASTERCOUNT - 1);
      cnt   <= '0;
      rdy_q <= '0;
      to_q  <= 1'b0;
      for (int i = 0; i < MASTERCOUNT; i++) rdata_q[i] <= '0;
    end else begin
      rdy_q <= '0;
      to_q  <= 1'b0;
      case (state)
        IDLE: if (req_any) begin
          gnt <= winner;
          cnt <= '0;
        end
        BUSY: begin
          if (s_rdy_i) begin
            rdata_q[gnt] <= s_data_i;
            rdy_q[gnt]   <= 1'b1;
          end else if (to_hit) begin
            rdata_q[gnt] <= '1;
            rdy_q[gnt]   <= 1'b1;
            to_q         <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
